// File: rtl/ticket_vending_ctrl.sv
// Multi-ticket fare controller: quotes a trip, collects coins, then dispenses tickets with change
// or refunds on cancel/timeout. All outputs are registered or decoded directly from registered state.
module ticket_vending_ctrl #(
  parameter int NUM_STATIONS  = 5,
  parameter int STN_W         = 3,
  parameter int FARE_PER_STOP = 5,
  parameter int MAX_TICKETS   = 5,
  parameter int TKT_W         = 3,
  parameter int COIN_W        = 6,
  parameter int MONEY_W       = 8,
  parameter int TIMEOUT_CYC   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [STN_W-1:0]   origin,
  input  logic [STN_W-1:0]   destination,
  input  logic [TKT_W-1:0]   tickets,
  input  logic               coin_valid,
  input  logic [COIN_W-1:0]  coin_value,
  input  logic               cancel,
  output logic               busy,
  output logic               req_error,
  output logic               coin_reject,
  output logic [MONEY_W-1:0] fare,
  output logic [MONEY_W-1:0] paid,
  output logic [MONEY_W-1:0] due,
  output logic               dispense_valid,
  output logic               refund_valid,
  output logic [TKT_W-1:0]   ticket_count,
  output logic [MONEY_W-1:0] change
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUOTE,
    S_PAY,
    S_DISPENSE,
    S_REFUND
  } state_t;

  state_t             state_q;
  logic [STN_W-1:0]   org_q, dst_q;
  logic [TKT_W-1:0]   tkt_q, ticket_count_q;
  logic [MONEY_W-1:0] fare_q, paid_q, due_q, change_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_error_q, coin_reject_q, dispense_q, refund_q;

  logic               req_ok_d, timeout_d;
  logic [STN_W-1:0]   span_d;
  logic [MONEY_W-1:0] fare_d, paid_d, due_d;
  logic [CNT_W-1:0]   cnt_d;

  // NOTE: every variable assigned here gets a value on every path, so no latches are inferred.
  always_comb begin
    req_ok_d  = (origin != '0) && (origin <= STN_W'(NUM_STATIONS)) &&
                (destination != '0) && (destination <= STN_W'(NUM_STATIONS)) &&
                (tickets != '0) && (tickets <= TKT_W'(MAX_TICKETS));
    span_d    = (org_q > dst_q) ? (org_q - dst_q) : (dst_q - org_q);
    fare_d    = MONEY_W'(FARE_PER_STOP) * (MONEY_W'(span_d) + MONEY_W'(1)) * MONEY_W'(tkt_q);
    paid_d    = coin_valid ? (paid_q + MONEY_W'(coin_value)) : paid_q;
    due_d     = (paid_d < fare_q) ? (fare_q - paid_d) : '0;
    cnt_d     = coin_valid ? '0 : (cnt_q + CNT_W'(1));
    timeout_d = !coin_valid && (cnt_d == CNT_W'(TIMEOUT_CYC));
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      org_q          <= '0;
      dst_q          <= '0;
      tkt_q          <= '0;
      fare_q         <= '0;
      paid_q         <= '0;
      due_q          <= '0;
      change_q       <= '0;
      ticket_count_q <= '0;
      cnt_q          <= '0;
      req_error_q    <= 1'b0;
      coin_reject_q  <= 1'b0;
      dispense_q     <= 1'b0;
      refund_q       <= 1'b0;
    end else begin
      req_error_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      dispense_q    <= 1'b0;
      refund_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          coin_reject_q <= coin_valid;
          if (req_valid) begin
            if (req_ok_d) begin
              org_q   <= origin;
              dst_q   <= destination;
              tkt_q   <= tickets;
              state_q <= S_QUOTE;
            end else begin
              req_error_q <= 1'b1;
            end
          end
        end
        S_QUOTE: begin
          coin_reject_q <= coin_valid;
          fare_q        <= fare_d;
          due_q         <= fare_d;
          paid_q        <= '0;
          cnt_q         <= '0;
          state_q       <= S_PAY;
        end
        S_PAY: begin
          paid_q <= paid_d;
          due_q  <= due_d;
          cnt_q  <= cnt_d;
          // A coin that completes payment beats a simultaneous cancel.
          if (paid_d >= fare_q) begin
            dispense_q     <= 1'b1;
            ticket_count_q <= tkt_q;
            change_q       <= paid_d - fare_q;
            state_q        <= S_DISPENSE;
          end else if (cancel || timeout_d) begin
            refund_q       <= 1'b1;
            ticket_count_q <= '0;
            change_q       <= paid_d;
            state_q        <= S_REFUND;
          end
        end
        S_DISPENSE, S_REFUND: begin
          coin_reject_q  <= coin_valid;
          fare_q         <= '0;
          paid_q         <= '0;
          due_q          <= '0;
          change_q       <= '0;
          ticket_count_q <= '0;
          cnt_q          <= '0;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign req_error      = req_error_q;
  assign coin_reject    = coin_reject_q;
  assign fare           = fare_q;
  assign paid           = paid_q;
  assign due            = due_q;
  assign dispense_valid = dispense_q;
  assign refund_valid   = refund_q;
  assign ticket_count   = ticket_count_q;
  assign change         = change_q;

endmodule

// File: tb/tb_ticket_vending_ctrl.sv
// Bench for ticket_vending_ctrl: directed stimulus pushes expected pulses into a queue,
// a negedge monitor pops and compares them (kind, cycle, ticket_count, change).
module tb_ticket_vending_ctrl;

  localparam int NUM_STATIONS  = 5;
  localparam int STN_W         = 3;
  localparam int FARE_PER_STOP = 5;
  localparam int MAX_TICKETS   = 5;
  localparam int TKT_W         = 3;
  localparam int COIN_W        = 6;
  localparam int MONEY_W       = 8;
  localparam int TIMEOUT_CYC   = 1000;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  logic [STN_W-1:0]   origin, destination;
  logic [TKT_W-1:0]   tickets;
  logic               coin_valid;
  logic [COIN_W-1:0]  coin_value;
  logic               cancel;
  logic               busy, req_error, coin_reject, dispense_valid, refund_valid;
  logic [MONEY_W-1:0] fare, paid, due, change;
  logic [TKT_W-1:0]   ticket_count;

  ticket_vending_ctrl #(
    .NUM_STATIONS(NUM_STATIONS), .STN_W(STN_W), .FARE_PER_STOP(FARE_PER_STOP),
    .MAX_TICKETS(MAX_TICKETS), .TKT_W(TKT_W), .COIN_W(COIN_W), .MONEY_W(MONEY_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .origin(origin),
    .destination(destination), .tickets(tickets), .coin_valid(coin_valid),
    .coin_value(coin_value), .cancel(cancel), .busy(busy), .req_error(req_error),
    .coin_reject(coin_reject), .fare(fare), .paid(paid), .due(due),
    .dispense_valid(dispense_valid), .refund_valid(refund_valid),
    .ticket_count(ticket_count), .change(change)
  );

  typedef enum int {EV_DISP, EV_REFUND, EV_REQERR, EV_COINREJ} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       tc;
    int       chg;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Pulse caused by the input driven now appears 'delay' cycles later.
  task automatic expect_ev(input ev_kind_t k, input int tc, input int chg, input int delay);
    ev_t e;
    e.kind = k;
    e.tc   = tc;
    e.chg  = chg;
    e.cyc  = cyc + delay;
    exp_q.push_back(e);
  endtask

  task automatic score(input ev_kind_t k);
    ev_t e;
    check($sformatf("pulse_%0d_expected", int'(k)), int'(exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("pulse_kind", int'(k), int'(e.kind));
    check("pulse_cycle", cyc, e.cyc);
    if (k == EV_DISP || k == EV_REFUND) begin
      check("ticket_count", int'(ticket_count), e.tc);
      check("change", int'(change), e.chg);
    end
  endtask

  always @(negedge clk) begin
    if (dispense_valid === 1'b1) score(EV_DISP);
    if (refund_valid === 1'b1)   score(EV_REFUND);
    if (req_error === 1'b1)      score(EV_REQERR);
    if (coin_reject === 1'b1)    score(EV_COINREJ);
  end

  task automatic drive_idle(input int n);
    req_valid  = 1'b0;
    coin_valid = 1'b0;
    coin_value = '0;
    cancel     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_req(input int o, input int d, input int t);
    origin      = STN_W'(o);
    destination = STN_W'(d);
    tickets     = TKT_W'(t);
    req_valid   = 1'b1;
    @(negedge clk);
    req_valid   = 1'b0;
  endtask

  task automatic do_coin(input int v, input bit c);
    coin_valid = 1'b1;
    coin_value = COIN_W'(v);
    cancel     = c;
    @(negedge clk);
    coin_valid = 1'b0;
    coin_value = '0;
    cancel     = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
  endtask

  // Request, pass through QUOTE, land in PAY and check the quote.
  task automatic to_pay(input int o, input int d, input int t, input int exp_fare);
    do_req(o, d, t);
    check("busy_quote", int'(busy), 1);
    drive_idle(1);
    check("fare_pay", int'(fare), exp_fare);
    check("due_pay", int'(due), exp_fare);
    check("paid_pay", int'(paid), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_fare"}, int'(fare), 0);
    check({tag, "_paid"}, int'(paid), 0);
    check({tag, "_due"}, int'(due), 0);
    check({tag, "_change"}, int'(change), 0);
    check({tag, "_tc"}, int'(ticket_count), 0);
    check({tag, "_pulses"}, int'({dispense_valid, refund_valid, req_error, coin_reject}), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive_idle(2);
    check_idle_zero("reset");
    reset = 1'b1;
    drive_idle(1);

    // 1: fare 30, coins 20 then 10, exact payment
    to_pay(2, 4, 2, 30);
    do_coin(20, 1'b0);
    check("t1_paid", int'(paid), 20);
    check("t1_due", int'(due), 10);
    expect_ev(EV_DISP, 2, 0, 1);
    do_coin(10, 1'b0);
    check("t1_due_disp", int'(due), 0);
    drive_idle(1);
    check_idle_zero("t1_after");

    // 2: reversed stations, overpay, coin during DISPENSE rejected, invalid requests
    to_pay(5, 1, 1, 25);
    do_coin(20, 1'b0);
    check("t2_due", int'(due), 5);
    expect_ev(EV_DISP, 1, 15, 1);
    do_coin(20, 1'b0);
    expect_ev(EV_COINREJ, 0, 0, 1);
    do_coin(9, 1'b0);
    check("t2_paid_idle", int'(paid), 0);
    expect_ev(EV_REQERR, 0, 0, 1);
    do_req(0, 1, 1);
    check("t2_busy_o0", int'(busy), 0);
    expect_ev(EV_REQERR, 0, 0, 1);
    do_req(1, 2, 6);
    check("t2_busy_t6", int'(busy), 0);
    expect_ev(EV_REQERR, 0, 0, 1);
    do_req(1, 6, 1);
    expect_ev(EV_REQERR, 0, 0, 1);
    do_req(1, 2, 0);
    check("t2_busy_t0", int'(busy), 0);
    drive_idle(1);

    // Largest quote, cancelled with nothing paid
    to_pay(1, 5, 5, 125);
    expect_ev(EV_REFUND, 0, 0, 1);
    do_cancel();
    drive_idle(1);

    // 3: coin 10, then cancel with coin 5 in the same cycle
    to_pay(3, 3, 5, 25);
    do_coin(10, 1'b0);
    expect_ev(EV_REFUND, 0, 15, 1);
    do_coin(5, 1'b1);
    check("t3_paid_refund", int'(paid), 15);
    drive_idle(1);
    check("t3_busy", int'(busy), 0);

    // 6: completing coin beats simultaneous cancel
    to_pay(1, 5, 1, 25);
    do_coin(10, 1'b0);
    do_coin(10, 1'b0);
    expect_ev(EV_DISP, 1, 0, 1);
    do_coin(5, 1'b1);
    drive_idle(1);

    // 4a: timeout exactly TIMEOUT_CYC idle cycles after the last coin
    to_pay(3, 3, 5, 25);
    expect_ev(EV_REFUND, 0, 10, TIMEOUT_CYC + 1);
    do_coin(10, 1'b0);
    drive_idle(TIMEOUT_CYC - 1);
    check("t4a_busy_before", int'(busy), 1);
    drive_idle(2);
    check("t4a_busy_after", int'(busy), 0);

    // 4b: a coin midway restarts the count
    to_pay(3, 3, 5, 25);
    do_coin(10, 1'b0);
    drive_idle(500);
    expect_ev(EV_REFUND, 0, 15, TIMEOUT_CYC + 1);
    do_coin(5, 1'b0);
    drive_idle(TIMEOUT_CYC - 1);
    check("t4b_busy_before", int'(busy), 1);
    drive_idle(2);

    // 5: coins in IDLE and QUOTE rejected, then reset mid-PAY
    expect_ev(EV_COINREJ, 0, 0, 1);
    do_coin(7, 1'b0);
    check("t5_paid_idle", int'(paid), 0);
    do_req(2, 2, 1);
    expect_ev(EV_COINREJ, 0, 0, 1);
    do_coin(3, 1'b0);
    check("t5_paid_quote", int'(paid), 0);
    check("t5_fare", int'(fare), 5);
    expect_ev(EV_REFUND, 0, 0, 1);
    do_cancel();
    drive_idle(1);

    to_pay(1, 5, 2, 50);
    do_coin(20, 1'b0);
    do_coin(20, 1'b0);
    check("t5_paid_40", int'(paid), 40);
    reset = 1'b0;
    drive_idle(1);
    check_idle_zero("t5_reset");
    reset = 1'b1;
    drive_idle(3);
    check("t5_busy_post", int'(busy), 0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
